ether_frame_feeder: RTL

- Upstream stage of the Ethernet transmitter; packs the ray-marcher output byte stream into fixed-size frame payloads.
- Buffers bytes in an internal FIFO. Once a full payload is available and the transmitter is idle, it pulses the transmitter trigger.
- Emits a 2-byte big-endian sequence header, then the payload, as MSB-first dibits. One dibit is produced per cycle while the transmitter's data-ready is high, and the final dibit is flagged.

---
 rtl/ether_pkg.sv | 26 ++
 rtl/byte_fifo.sv | 57 +++++
 rtl/ether_frame_feeder.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/ether_pkg.sv
// rtl/ether_pkg.sv - shared types and constants for the Ethernet frame feeder
package ether_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } feeder_state_t;

  localparam int SEQ_BYTES       = 2;
  localparam int DIBITS_PER_BYTE = 4;

  // Dibit k of a byte, most significant pair first
  function automatic logic [1:0] dibit_sel(input logic [7:0] byte_val, input logic [1:0] k);
    logic [1:0] d;
    case (k)
      2'd0:    d = byte_val[7:6];
      2'd1:    d = byte_val[5:4];
      2'd2:    d = byte_val[3:2];
      default: d = byte_val[1:0];
    endcase
    return d;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - fall-through register FIFO of bytes with registered full flag
module byte_fifo #(
  parameter int DEPTH = 256,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic [7:0]    head,
  output logic [CW-1:0] count,
  output logic          full
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_next;
  logic          do_push;

  // Pushes are dropped while full; pops are trusted never to underflow
  assign do_push = push && !full;
  assign head    = mem[rd_ptr];

  // Occupancy after this cycle's push/pop; both at once leaves it unchanged
  always_comb begin
    count_next = count;
    case ({do_push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // Pointers wrap naturally since DEPTH is a power of two; full is registered
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
      full  <= (count_next == CW'(DEPTH));
    end
  end

  // Storage array, no reset needed since pointers define validity
  always_ff @(posedge clk_in) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ether_frame_feeder.sv
// rtl/ether_frame_feeder.sv - packs a byte stream into sequenced frames of MSB-first dibits
module ether_frame_feeder
  import ether_pkg::*;
#(
  parameter int PAYLOAD_BYTES = 128,
  parameter int FIFO_DEPTH    = 256
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [7:0]  s_data_in,
  input  logic        s_valid_in,
  output logic        s_ready_out,
  input  logic        tx_ready_in,
  input  logic        tx_data_ready_in,
  output logic        tx_trigger_out,
  output logic [1:0]  tx_data_out,
  output logic        tx_last_dibit_out,
  output logic [15:0] frames_sent_out,
  output logic        frame_err_out
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = $clog2(PAYLOAD_BYTES + SEQ_BYTES);
  localparam logic [BW-1:0] LAST_B      = BW'(PAYLOAD_BYTES + SEQ_BYTES - 1);
  localparam logic [BW-1:0] FIRST_PAYLD = BW'(SEQ_BYTES);
  localparam logic [1:0]    LAST_K      = 2'(DIBITS_PER_BYTE - 1);

  feeder_state_t state_q, state_d;
  logic [BW-1:0] b_q, b_d;
  logic [1:0]    k_q, k_d;
  logic [15:0]   seq_q, seq_d;
  logic          err_q, err_d;
  logic          flush_q, flush_d;
  logic          fifo_pop;
  logic [7:0]    head;
  logic [CW-1:0] count;
  logic          full;
  logic [7:0]    cur_byte;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .push      (s_valid_in),
    .push_data (s_data_in),
    .pop       (fifo_pop),
    .head      (head),
    .count     (count),
    .full      (full)
  );

  assign s_ready_out     = !full;
  assign frames_sent_out = seq_q;
  assign frame_err_out   = err_q;

  // Header bytes carry the sequence number; payload comes from the FIFO head
  always_comb begin
    cur_byte = head;
    if (b_q == BW'(0))      cur_byte = seq_q[15:8];
    else if (b_q == BW'(1)) cur_byte = seq_q[7:0];
  end

  // Next-state, datapath updates and frame outputs
  always_comb begin
    state_d           = state_q;
    b_d               = b_q;
    k_d               = k_q;
    seq_d             = seq_q;
    err_d             = err_q;
    flush_d           = flush_q;
    fifo_pop          = 1'b0;
    tx_trigger_out    = 1'b0;
    tx_data_out       = 2'b00;
    tx_last_dibit_out = 1'b0;
    case (state_q)
      IDLE: begin
        if (tx_ready_in && count >= CW'(PAYLOAD_BYTES)) begin
          tx_trigger_out = 1'b1;
          state_d        = ARMED;
        end
      end
      ARMED, SEND: begin
        if (flush_q) begin
          // Aborted frame: discard its unsent payload bytes, one per cycle
          if (b_q >= FIRST_PAYLD) fifo_pop = 1'b1;
          if (b_q == LAST_B) begin
            seq_d   = seq_q + 16'd1;
            flush_d = 1'b0;
            state_d = DONE;
          end else begin
            b_d = b_q + BW'(1);
          end
        end else begin
          // Dibit is presented in ARMED too, so the first consume cycle sees it
          tx_data_out = dibit_sel(cur_byte, k_q);
          if (tx_data_ready_in) begin
            tx_last_dibit_out = (b_q == LAST_B) && (k_q == LAST_K);
            state_d           = SEND;
            if (k_q == LAST_K) begin
              k_d = 2'd0;
              if (b_q >= FIRST_PAYLD) fifo_pop = 1'b1;
              if (b_q == LAST_B) begin
                seq_d   = seq_q + 16'd1;
                state_d = DONE;
              end else begin
                b_d = b_q + BW'(1);
              end
            end else begin
              k_d = k_q + 2'd1;
            end
          end else if (state_q == SEND) begin
            err_d   = 1'b1;
            flush_d = 1'b1;
          end
        end
      end
      DONE: begin
        b_d     = '0;
        k_d     = 2'd0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any frame in flight
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      b_q     <= '0;
      k_q     <= 2'd0;
      seq_q   <= 16'd0;
      err_q   <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      k_q     <= k_d;
      seq_q   <= seq_d;
      err_q   <= err_d;
      flush_q <= flush_d;
    end
  end

endmodule
